// File: rtl/argmax_classifier_pkg.sv
// Shared network parameters for the classifier back end: output layer size,
// index width helper, argmax FSM state type and default decision threshold.
package nn_parameters;

   localparam int OUT_SIZE_2 = 10;

   localparam longint THRESHOLD_DEFAULT = 0;

   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int IDX_W = idx_width(OUT_SIZE_2);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// Request/result bundle between the dense-layer output stage and the argmax
// classifier; master drives the scores and start, slave returns the result.
interface argmax_classifier_if
   import nn_parameters::*;
#(
   parameter int N_CLASSES = OUT_SIZE_2,
   parameter int SCORE_W   = 48,
   parameter int IDX_W     = idx_width(N_CLASSES)
);
   logic                               start;
   logic [N_CLASSES-1:0][SCORE_W-1:0]  score_vector;
   logic                               busy;
   logic                               valid;
   logic [IDX_W-1:0]                   class_idx;
   logic signed [SCORE_W-1:0]          max_score;
   logic                               no_match;

   modport master (
      output start, score_vector,
      input  busy, valid, class_idx, max_score, no_match
   );

   modport slave (
      input  start, score_vector,
      output busy, valid, class_idx, max_score, no_match
   );
endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over a snapshot of class scores, one compare per cycle.
// Optional threshold check on the winner is enabled by ARGMAX_THRESHOLD_EN.
module argmax_classifier
   import nn_parameters::*;
#(
   parameter int                        N_CLASSES = OUT_SIZE_2,
   parameter int                        SCORE_W   = 48,
   parameter logic signed [SCORE_W-1:0] THRESHOLD = SCORE_W'(THRESHOLD_DEFAULT)
) (
   input logic                clk,
   input logic                rst_n,
   argmax_classifier_if.slave bus
);

   localparam int CNT_W = idx_width(N_CLASSES);

   typedef logic signed [SCORE_W-1:0] score_t;

   argmax_state_t    state;
   argmax_state_t    state_nxt;
   score_t           snap [N_CLASSES];
   logic [CNT_W-1:0] cnt;
   score_t           best;
   logic [CNT_W-1:0] best_idx;
   score_t           elem;
   score_t           best_nxt;
   logic [CNT_W-1:0] best_idx_nxt;
   logic             last;
   logic             accept;
   logic             busy_c;
   logic             valid_c;
   logic [CNT_W-1:0] res_idx;
   score_t           res_max;

   assign accept = (state == ST_IDLE) && bus.start;
   assign last   = (cnt == CNT_W'(N_CLASSES - 1));
   assign elem   = snap[cnt];

   // Strictly-greater replacement keeps the lowest index on ties.
   always_comb begin
      best_nxt     = best;
      best_idx_nxt = best_idx;
      if (elem > best) begin
         best_nxt     = elem;
         best_idx_nxt = cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_SCAN;
         ST_SCAN: if (last)      state_nxt = ST_DONE;
         ST_DONE:                state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_c  = (state == ST_SCAN);
      valid_c = (state == ST_DONE);
   end

   // Snapshot is seeded with element 0 as the running best; counter parks at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CLASSES; i++) snap[i] <= '0;
         cnt      <= '0;
         best     <= '0;
         best_idx <= '0;
      end else if (accept) begin
         for (int i = 0; i < N_CLASSES; i++) snap[i] <= score_t'(bus.score_vector[i]);
         cnt      <= '0;
         best     <= score_t'(bus.score_vector[0]);
         best_idx <= '0;
      end else if (state == ST_SCAN) begin
         best     <= best_nxt;
         best_idx <= best_idx_nxt;
         if (!last) cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_idx <= '0;
         res_max <= '0;
      end else if ((state == ST_SCAN) && last) begin
         res_idx <= best_idx_nxt;
         res_max <= best_nxt;
      end
   end

`ifdef ARGMAX_THRESHOLD_EN
   logic res_nm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        res_nm <= 1'b0;
      else if ((state == ST_SCAN) && last) res_nm <= (best_nxt < THRESHOLD);
   end

   assign bus.no_match = res_nm;
`else
   assign bus.no_match = 1'b0;
`endif

   assign bus.busy      = busy_c;
   assign bus.valid     = valid_c;
   assign bus.class_idx = res_idx;
   assign bus.max_score = res_max;

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier with 10 classes of 48-bit scores;
// threshold expectations follow ARGMAX_THRESHOLD_EN with THRESHOLD=1.
module tb_argmax_classifier;
   import nn_parameters::*;

   localparam int N = 10;
   localparam int W = 48;

`ifdef ARGMAX_THRESHOLD_EN
   localparam bit TH_EN = 1'b1;
`else
   localparam bit TH_EN = 1'b0;
`endif

   localparam longint VA [N] = '{0, 5, 3, 9, 2, 9, 1, 0, 0, 4};
   localparam longint VZ [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
   localparam longint VN [N] = '{-7, -3, -100, -8, -9, -10, -11, -12, -50,
                                 64'shFFFF_8000_0000_0000};
   localparam longint VC [N] = '{10, 2, 30, 4, 5, 6, 7, 8, 9, 1};
   localparam longint VY [N] = '{1, 2, 3, 4, 5, 6, 7, 8, 3,
                                 64'sh0000_7FFF_FFFF_FFFF};

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   cyc       = 0;
   int   busy_cnt  = 0;
   int   valid_cnt = 0;
   int   t0        = 0;

   always #5 clk = ~clk;

   argmax_classifier_if #(.N_CLASSES(N), .SCORE_W(W)) bus ();

   argmax_classifier #(
      .N_CLASSES(N),
      .SCORE_W  (W),
      .THRESHOLD(48'sd1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.busy)  busy_cnt++;
      if (bus.valid) valid_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_vec(input longint v [N]);
      for (int i = 0; i < N; i++) bus.score_vector[i] = v[i][W-1:0];
   endtask

   // Start is sampled at the next edge (edge T); t0 marks that edge.
   task automatic launch(input longint v [N]);
      drive_vec(v);
      bus.start = 1'b1;
      busy_cnt  = 0;
      tick();
      t0        = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_res(input string tag, input longint exp_idx, input longint exp_max,
                           input bit exp_nm);
      int k = 0;
      while (!bus.valid && k < 40) begin
         tick();
         k++;
      end
      check_val({tag, "_valid"}, 64'(bus.valid), 64'd1);
      check_val({tag, "_latency"}, 64'(cyc - t0 + 1), 64'd11);
      check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd10);
      check_val({tag, "_class_idx"}, 64'(bus.class_idx), 64'(exp_idx));
      check_val({tag, "_max_score"}, longint'(bus.max_score), exp_max);
      check_val({tag, "_no_match"}, 64'(bus.no_match), 64'(exp_nm));
      tick();
      check_val({tag, "_valid_drop"}, 64'(bus.valid), 64'd0);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.score_vector = '0;
      tick();
      tick();
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_valid", 64'(bus.valid), 64'd0);
      check_val("rst_class_idx", 64'(bus.class_idx), 64'd0);
      check_val("rst_max_score", longint'(bus.max_score), 64'd0);
      check_val("rst_no_match", 64'(bus.no_match), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic scan with a tie at 9: lowest index 3 wins.
      launch(VA);
      wait_res("basic", 3, 9, 1'b0);

      launch(VZ);
      wait_res("zeros", 0, 0, TH_EN);

      launch(VN);
      wait_res("negative", 1, -3, TH_EN);

      // New scores and a second start at T+4 must be ignored.
      launch(VC);
      tick();
      tick();
      tick();
      drive_vec('{100, 100, 100, 100, 100, 100, 100, 100, 100, 100});
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_val("hold_busy_mid", 64'(bus.busy), 64'd1);
      wait_res("hold", 2, 30, 1'b0);

      // Reset asserted between edges T+4 and T+5 of a scan.
      launch(VA);
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      #1;
      check_val("midrst_busy", 64'(bus.busy), 64'd0);
      check_val("midrst_valid", 64'(bus.valid), 64'd0);
      check_val("midrst_class_idx", 64'(bus.class_idx), 64'd0);
      check_val("midrst_max_score", longint'(bus.max_score), 64'd0);
      check_val("midrst_no_match", 64'(bus.no_match), 64'd0);
      valid_cnt = 0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check_val("midrst_no_valid", 64'(valid_cnt), 64'd0);
      check_val("midrst_idle_busy", 64'(bus.busy), 64'd0);
      launch(VA);
      wait_res("after_rst", 3, 9, 1'b0);

      // Back-to-back: start lands in the cycle right after valid.
      launch(VN);
      wait_res("b2b_first", 1, -3, TH_EN);
      launch(VY);
      wait_res("b2b_second", 9, 64'sh0000_7FFF_FFFF_FFFF, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N_CLASSES, default OUT_SIZE_2 (from nn_parameters), meaning the number of scored classes (minimum 1).
REQ-002 SHALL have parameter SCORE_W, default 48, meaning the signed score width.
REQ-003 SHALL have parameter THRESHOLD, default 0, meaning the signed minimum winning score (used only with REQ-024).
REQ-004 SHALL use one clock and an asynchronous active-low reset.
REQ-005 SHALL have port clk, input, 1, meaning the rising-edge system clock.
REQ-006 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, meaning a one-cycle request to classify the current scores.
REQ-008 SHALL have port score_vector, input, N_CLASSES x SCORE_W signed, meaning the final dense-layer outputs.
REQ-009 SHALL have port busy, output, 1, meaning a scan is in progress.
REQ-010 SHALL have port valid, output, 1, meaning a one-cycle pulse that the result is ready.
REQ-011 SHALL have port class_idx, output, IDX_W, meaning the winning class index.
REQ-012 SHALL have port max_score, output, SCORE_W signed, meaning the winning score.
REQ-013 SHALL have port no_match, output, 1, meaning the winner is below THRESHOLD.

Function
REQ-014 SHALL implement the FSM states IDLE, SCAN and DONE.
- IDLE -> SCAN on start.
- SCAN -> DONE after element N_CLASSES-1 is compared.
- DONE -> IDLE unconditionally.
REQ-015 SHALL, on a start accepted at edge T, snapshot all of score_vector into internal registers at edge T; later input changes SHALL NOT affect the result.
REQ-016 SHALL, in SCAN, compare one element per cycle using a single comparator and an index counter running 0..N_CLASSES-1; the counter SHALL NOT wrap.
REQ-017 SHALL seed the running best with element 0 and index 0, and replace the best only when an element is strictly greater in signed SCORE_W comparison, so ties resolve to the lowest index.
REQ-018 SHALL keep busy high from T+1 through the last SCAN cycle, and pulse valid high for exactly one cycle, in DONE, at T+N_CLASSES+1.
REQ-019 SHALL update class_idx, max_score and no_match only on entry to DONE, and hold them until the next DONE.
REQ-020 SHALL ignore start while busy or in DONE, dropping it without queuing.
REQ-021 SHALL, when N_CLASSES=1, take one SCAN cycle and return index 0.
REQ-022 SHALL accept a start asserted in the cycle after valid, because the FSM is in IDLE by then.

Reset
REQ-023 SHALL, while rst_n=0 and at any time including mid-scan, immediately force the state to IDLE, busy=0, valid=0, class_idx=0, max_score=0, no_match=0, clear the counter and snapshot, and discard any partial result; no valid pulse SHALL follow release.

Configuration
REQ-024 SHALL provide the macro ARGMAX_THRESHOLD_EN.
- Defined: no_match is registered in DONE as (best < THRESHOLD), signed.
- Undefined: no_match is constant 0, no threshold comparator is built, and the port remains.

Structure
REQ-025 SHALL place IDX_W (= $clog2(N_CLASSES) with a minimum of 1), the FSM state enum type and the default THRESHOLD in package nn_parameters next to OUT_SIZE_2.
REQ-026 SHALL contain no sub-module; the snapshot, comparator, counter and FSM live in one module.

Verification (bench with N_CLASSES=10, SCORE_W=48)
REQ-027 SHALL verify: scores {0,5,3,9,2,9,1,0,0,4}, start -> valid at T+11, class_idx=3, max_score=9, busy high for 10 cycles.
REQ-028 SHALL verify: all scores 0 -> class_idx=0, max_score=0, and with ARGMAX_THRESHOLD_EN and THRESHOLD=1, no_match=1.
REQ-029 SHALL verify: scores {-7,-3,-100,...,-50}, with the negative 48-bit extreme 0x8000_0000_0000 at index 9 -> class_idx=1, max_score=-3 (signed compare).
REQ-030 SHALL verify: score_vector changed and start re-pulsed at T+4 -> both ignored, and the result matches the T snapshot.
REQ-031 SHALL verify: rst_n low at T+5 mid-scan -> all outputs 0 at once, no valid after release, and a fresh start completes normally.
REQ-032 SHALL verify: start at the cycle after valid -> a second valid 11 cycles later, with max score 0x7FFF_FFFF_FFFF at index 9 -> class_idx=9.
